rdata_packetizer: RTL
=====================

# rdata_packetizer

Sits between the read-data async FIFO master port and the DMA S2MM (C2H) stream, in the `axi_aclk` domain. Groups 512-bit DDR read beats into C2H packets. Each packet has a programmable beat count, full `tkeep`, and `tlast` on the final beat. A one-beat hold register defers each beat until it is known whether that beat ends the packet. The packet then closes on one of three events: the length is reached, software flushes, or (optionally) the input goes idle for a set time.

## Interface
Parameters:
- `DATA_WIDTH`, 512, stream data width in bits; `tkeep` width is `DATA_WIDTH/8`.
- `MAX_PKT_BEATS`, 64, largest packet in beats; the beat counter is `$clog2(MAX_PKT_BEATS+1)` bits.
- `TIMEOUT_WIDTH`, 16, width of the idle-timeout counter and of `timeout_cycles`.

Ports:
- `axi_aclk`  in  1  sole clock.
- `axi_aresetn`  in  1  reset, synchronous, active-low.
- `S_AXIS_RDATA_tdata`  in  DATA_WIDTH  read beat from the rdata FIFO.
- `S_AXIS_RDATA_tvalid`  in  1  beat valid.
- `S_AXIS_RDATA_tready`  out  1  beat accepted when high with tvalid.
- `M_AXIS_C2H_tdata`  out  DATA_WIDTH  beat to DMA.
- `M_AXIS_C2H_tkeep`  out  DATA_WIDTH/8  all ones whenever tvalid is high.
- `M_AXIS_C2H_tlast`  out  1  final beat of packet.
- `M_AXIS_C2H_tvalid`  out  1  output valid.
- `M_AXIS_C2H_tready`  in  1  DMA ready.
- `pkt_len`  in  16  beats per packet. 0 means MAX_PKT_BEATS; values above the maximum are clamped to it.
- `timeout_cycles`  in  TIMEOUT_WIDTH  idle cycles before a forced close; 0 disables the timeout.
- `flush`  in  1  single-cycle pulse that closes the open packet.
- `pkt_count`  out  32  number of packets completed (counted when a `tlast` beat handshakes); wraps.

## Operation
- Storage: hold register (`hold_valid`, `hold_data`, `hold_last`) and output register (M_AXIS signals).
- `out_free` = `!M_AXIS_C2H_tvalid || M_AXIS_C2H_tready`.
- `S_AXIS_RDATA_tready` = `!hold_valid || out_free`. Sustained throughput is one beat per cycle.
- Length latch: `pkt_len` is latched when the first beat of a packet is accepted (beat counter 0). Changes during a packet take effect from the next packet.
- Per accepted beat:
  - Increment the beat counter.
  - Set `hold_last` if the counter equals the latched length; the counter then resets to 0.
- Release of the hold register into the output register happens when `hold_valid && out_free` and at least one of these holds:
  - `hold_last`: released with tlast=1.
  - An input beat is accepted the same cycle: released with tlast=0, and the new beat fills the hold register.
  - `flush_pending`: released with tlast=1, beat counter reset.
  - Timeout expired: released with tlast=1, beat counter reset.
- Flush:
  - `flush` sets the sticky `flush_pending`.
  - `flush_pending` clears when the hold register is released with tlast=1.
  - If the hold register is empty, `flush_pending` clears on the next cycle with no effect.
  - If a beat is accepted in the same cycle as `flush`, that beat becomes the one closed by the flush.
- Output register: loads on release; otherwise clears tvalid on a handshake. Contents are held stable while `tvalid && !tready`.

## Timing
- Reset (`axi_aresetn`=0 sampled on the clock edge):
  - `M_AXIS_C2H_tvalid`/`tlast` = 0, `tdata` = 0, `tkeep` = 0.
  - `hold_valid` = 0, beat counter = 0, timeout counter = 0, `flush_pending` = 0, `pkt_count` = 0.
  - `S_AXIS_RDATA_tready` = 1 from the first cycle after reset is released.
- Reset mid-packet: the held beat and output beat are discarded without a tlast. The DMA side must be re-armed by software.
- Latency:
  - A beat that ends a packet (length reached) is accepted at cycle N and appears on M at cycle N+2.
  - A non-final beat appears at cycle M+1, where M is the cycle in which the next beat is accepted.
- Backpressure: if `M_AXIS_C2H_tready` is held low, at most 2 beats are stored, then `S_AXIS_RDATA_tready` drops combinationally.
- Simultaneous events: `hold_last`, flush and timeout in one cycle close only one packet (one tlast) and increment `pkt_count` by 1.

## Configuration
- `RDATA_PKT_TIMEOUT_EN` defined:
  - The idle counter increments each cycle that `hold_valid && !S_AXIS_RDATA_tvalid`.
  - It clears when a beat is accepted or the hold register is released.
  - When it reaches a nonzero `timeout_cycles`, the held beat is released with tlast=1.
- Not defined: the counter logic is absent, `timeout_cycles` is ignored, and only the length limit or `flush` closes a packet.

## Test plan
- Length closes packets: `pkt_len`=4, 8 back-to-back beats with values 0..7, tready=1 → two packets with tlast on beats 3 and 7; `pkt_count`=2; no bubbles after the first output.
- Backpressure: `pkt_len`=4, tready low for 10 cycles while 6 beats are offered → only 2 beats accepted until tready rises. Output order is intact and `tdata` is stable while stalled.
- Flush: `pkt_len`=16, send 3 beats, idle, pulse `flush` → beat 3 is emitted with tlast=1. The next packet restarts its count (4 more beats then flush gives tlast on the 4th).
- Timeout, with `RDATA_PKT_TIMEOUT_EN`: `timeout_cycles`=5, `pkt_len`=16, send 2 beats then idle → 2nd beat is emitted with tlast about 6 cycles after acceptance. With `timeout_cycles`=0 there is no output until `flush`.
- Edge lengths: `pkt_len`=0 → 64-beat packets. `pkt_len`=1 → every beat has tlast. `pkt_len` changed mid-packet → the current packet keeps its old length.
- Mid-packet reset: assert `axi_aresetn`=0 with one held beat and one output beat → next cycle tvalid=0 and `pkt_count`=0. A post-reset packet of 4 beats is correct.

Source files
------------

// File: rtl/rdata_packetizer.sv
// rtl/rdata_packetizer.sv - groups read beats into C2H packets by length, flush or idle timeout
// Optional idle timeout enabled by defining RDATA_PKT_TIMEOUT_EN.
module rdata_packetizer #(
    parameter int DATA_WIDTH    = 512,
    parameter int MAX_PKT_BEATS = 64,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     axi_aclk,
    input  logic                     axi_aresetn,
    input  logic [DATA_WIDTH-1:0]    S_AXIS_RDATA_tdata,
    input  logic                     S_AXIS_RDATA_tvalid,
    output logic                     S_AXIS_RDATA_tready,
    output logic [DATA_WIDTH-1:0]    M_AXIS_C2H_tdata,
    output logic [DATA_WIDTH/8-1:0]  M_AXIS_C2H_tkeep,
    output logic                     M_AXIS_C2H_tlast,
    output logic                     M_AXIS_C2H_tvalid,
    input  logic                     M_AXIS_C2H_tready,
    input  logic [15:0]              pkt_len,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
    input  logic                     flush,
    output logic [31:0]              pkt_count
);
    localparam int CW = $clog2(MAX_PKT_BEATS + 1);
    localparam logic [CW-1:0] MAX_LEN = CW'(MAX_PKT_BEATS);

    logic                  hold_valid;
    logic                  hold_last;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [CW-1:0]         beat_cnt;
    logic [CW-1:0]         len_q;
    logic                  flush_pending;

    logic                  out_free;
    logic                  accept;
    logic                  timeout_hit;
    logic                  release_en;
    logic                  release_last;
    logic [CW-1:0]         len_eff;
    logic [CW-1:0]         cnt_base;
    logic [CW-1:0]         cur_len;
    logic [CW-1:0]         cnt_inc;
    logic                  in_last;

    always_comb begin
        out_free            = !M_AXIS_C2H_tvalid || M_AXIS_C2H_tready;
        S_AXIS_RDATA_tready = !hold_valid || out_free;
        accept              = S_AXIS_RDATA_tvalid && S_AXIS_RDATA_tready;
        release_last        = hold_last || flush_pending || timeout_hit;
        release_en          = hold_valid && out_free && (release_last || accept);
        if (pkt_len == 16'd0 || 32'(pkt_len) > MAX_PKT_BEATS)
            len_eff = MAX_LEN;
        else
            len_eff = pkt_len[CW-1:0];
        // A beat accepted alongside a closing release starts a fresh packet.
        cnt_base = (release_en && release_last) ? '0 : beat_cnt;
        cur_len  = (cnt_base == '0) ? len_eff : len_q;
        cnt_inc  = cnt_base + 1'b1;
        in_last  = (cnt_inc == cur_len);
    end

`ifdef RDATA_PKT_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] idle_cnt;

    assign timeout_hit = hold_valid && (timeout_cycles != '0) && (idle_cnt >= timeout_cycles);

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn)
            idle_cnt <= '0;
        else if (accept || release_en)
            idle_cnt <= '0;
        else if (hold_valid && !S_AXIS_RDATA_tvalid && idle_cnt != '1)
            idle_cnt <= idle_cnt + 1'b1;
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^timeout_cycles;
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            hold_valid        <= 1'b0;
            hold_last         <= 1'b0;
            hold_data         <= '0;
            beat_cnt          <= '0;
            len_q             <= '0;
            flush_pending     <= 1'b0;
            M_AXIS_C2H_tvalid <= 1'b0;
            M_AXIS_C2H_tlast  <= 1'b0;
            M_AXIS_C2H_tdata  <= '0;
            M_AXIS_C2H_tkeep  <= '0;
            pkt_count         <= '0;
        end else begin
            if (accept) begin
                hold_valid <= 1'b1;
                hold_data  <= S_AXIS_RDATA_tdata;
                hold_last  <= in_last;
                beat_cnt   <= in_last ? '0 : cnt_inc;
                if (cnt_base == '0)
                    len_q <= len_eff;
            end else begin
                beat_cnt <= cnt_base;
                if (release_en) begin
                    hold_valid <= 1'b0;
                    hold_last  <= 1'b0;
                end
            end

            // A flush landing with a new beat targets that beat, not the one leaving.
            if (flush && accept)
                flush_pending <= 1'b1;
            else if (release_en && release_last)
                flush_pending <= 1'b0;
            else if (flush)
                flush_pending <= 1'b1;
            else if (!hold_valid)
                flush_pending <= 1'b0;

            if (release_en) begin
                M_AXIS_C2H_tvalid <= 1'b1;
                M_AXIS_C2H_tdata  <= hold_data;
                M_AXIS_C2H_tkeep  <= '1;
                M_AXIS_C2H_tlast  <= release_last;
            end else if (M_AXIS_C2H_tready) begin
                M_AXIS_C2H_tvalid <= 1'b0;
                M_AXIS_C2H_tlast  <= 1'b0;
            end

            if (M_AXIS_C2H_tvalid && M_AXIS_C2H_tready && M_AXIS_C2H_tlast)
                pkt_count <= pkt_count + 1'b1;
        end
    end
endmodule
